note_tick_gen: RTL and testbench

// - Upstream driver of the audio sine-table address counter: produces the 1-cycle enable pulses that step the table index.
// - Pulse rate = f_note * TABLE_SIZE, so one full table sweep equals one period of the selected note.
// - Timed playback: plays one note (or rest) for a given number of milliseconds, then stops and reports completion.
// - Game logic (ball hits, pocket events) issues start requests.

---
 rtl/audio_pkg.sv | 31 +++
 rtl/strobe_div.sv | 41 ++++
 rtl/note_tick_gen.sv | 119 +++++++++++
 tb/tb_note_tick_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - note table, divider helpers and shared types for the note tick generator
package audio_pkg;

    typedef enum logic [3:0] {
        NOTE_C4, NOTE_CS4, NOTE_D4, NOTE_DS4, NOTE_E4, NOTE_F4,
        NOTE_FS4, NOTE_G4, NOTE_GS4, NOTE_A4, NOTE_AS4, NOTE_B4, NOTE_REST
    } note_t;

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    localparam int NUM_NOTES = 12;

    // Ascending pitch order; index 0 therefore yields the largest divider.
    localparam int NOTE_FREQ_HZ [NUM_NOTES] = '{
        262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494
    };

    function automatic int note_div(input int freq, input int clk_hz, input int table_size);
        int d;
        d = clk_hz / (freq * table_size);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/strobe_div.sv
// rtl/strobe_div.sv - loadable mod-N counter emitting a 1-cycle strobe on its last count
module strobe_div #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] mod_in,
    input  logic         en,
    output logic         strobe
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] mod_q, mod_d;

    always_comb begin
        mod_d  = mod_q;
        cnt_d  = cnt_q;
        strobe = en && !load && !clr && (cnt_q == mod_q - W'(1));
        if (load) begin
            mod_d = mod_in;
            cnt_d = '0;
        end else if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = strobe ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
            mod_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mod_q <= mod_d;
        end
    end

endmodule

// File: rtl/note_tick_gen.sv
// rtl/note_tick_gen.sv - timed note playback producing table-step ticks at f_note * TABLE_SIZE
module note_tick_gen
    import audio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TABLE_SIZE  = 256,
    parameter int NOTE_BITS   = 4,
    parameter int DUR_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 start,
    input  logic [NOTE_BITS-1:0] note_idx,
    input  logic [DUR_BITS-1:0]  dur_ms,
    output logic                 tick,
    output logic                 sound_on,
    output logic                 busy,
    output logic                 done
);

    localparam int MAX_DIV    = note_div(NOTE_FREQ_HZ[0], CLK_FREQ_HZ, TABLE_SIZE);
    localparam int DIV_W      = $clog2(MAX_DIV + 1);
    localparam int MS_DIV_VAL = ms_div(CLK_FREQ_HZ);
    localparam int MS_W       = $clog2(MS_DIV_VAL + 1);

    state_t              state_q, state_d;
    logic [DUR_BITS-1:0] rem_q, rem_d;
    logic                rest_q, rest_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;

    logic [DIV_W-1:0]    div_sel;
    logic                is_rest;
    logic                play;
    logic                finish;
    logic                note_strobe;
    logic                ms_strobe;

    always_comb begin
        div_sel = DIV_W'(1);
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (int'(note_idx) == i) begin
                div_sel = DIV_W'(note_div(NOTE_FREQ_HZ[i], CLK_FREQ_HZ, TABLE_SIZE));
            end
        end
    end

    assign is_rest = int'(note_idx) >= int'(NOTE_REST);
    assign play    = (state_q == S_PLAY);

    strobe_div #(.W(DIV_W)) u_note_div (
        .clk    (clk),
        .resetN (resetN),
        .clr    (!play),
        .load   (start),
        .mod_in (div_sel),
        .en     (play),
        .strobe (note_strobe)
    );

    strobe_div #(.W(MS_W)) u_ms_div (
        .clk    (clk),
        .resetN (resetN),
        .clr    (!play),
        .load   (start),
        .mod_in (MS_W'(MS_DIV_VAL)),
        .en     (play),
        .strobe (ms_strobe)
    );

    // Finishing on the last ms expiry (or immediately for dur 0) keeps remaining from underflowing.
    assign finish = play && ((rem_q == '0) || ((rem_q == DUR_BITS'(1)) && ms_strobe));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rest_d  = rest_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (start) begin
            state_d = S_PLAY;
            rem_d   = dur_ms;
            rest_d  = is_rest;
        end else if (play) begin
            if (finish) begin
                state_d = S_IDLE;
                rem_d   = '0;
                done_d  = 1'b1;
            end else begin
                if (ms_strobe) begin
                    rem_d = rem_q - DUR_BITS'(1);
                end
                tick_d = note_strobe && !rest_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            rest_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            rest_q  <= rest_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign tick     = tick_q;
    assign done     = done_q;
    assign busy     = play;
    assign sound_on = play && !rest_q;

endmodule

// File: tb/tb_note_tick_gen.sv
// tb/tb_note_tick_gen.sv - directed self-checking bench for note_tick_gen at a 5 MHz scaled clock
module tb_note_tick_gen;

    // 5 MHz: MS_DIV=5000, A4 div=44, C4 div=74, B4 div=39
    localparam int CLK_HZ = 5_000_000;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic [3:0] note_idx = 4'd0;
    logic [7:0] dur_ms = 8'd0;
    logic       tick, sound_on, busy, done;

    int errors = 0;
    int checks = 0;

    note_tick_gen #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TABLE_SIZE  (256),
        .NOTE_BITS   (4),
        .DUR_BITS    (8)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start),
        .note_idx (note_idx),
        .dur_ms   (dur_ms),
        .tick     (tick),
        .sound_on (sound_on),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input int n, input int d);
        @(negedge clk);
        start    = 1'b1;
        note_idx = n[3:0];
        dur_ms   = d[7:0];
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Called at the negedge of PLAY cycle 1; k indexes PLAY cycles from there.
    task automatic observe(input string tag, input int exp_ticks, input int exp_first,
                           input int exp_space, input int exp_done, input int exp_snd);
        int ticks, first, last, bad_space, bad_lvl, done_at;
        ticks = 0; first = 0; last = 0; bad_space = 0; bad_lvl = 0; done_at = 0;
        for (int k = 1; k <= exp_done + 10; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                done_at = k;
                if (busy !== 1'b0 || sound_on !== 1'b0 || tick !== 1'b0) bad_lvl++;
                break;
            end
            if (busy !== 1'b1 || int'(sound_on) != exp_snd) bad_lvl++;
            if (tick) begin
                ticks++;
                if (first == 0) first = k;
                else if (k - last != exp_space) bad_space++;
                last = k;
            end
        end
        chk({tag, "_ticks"}, ticks, exp_ticks);
        chk({tag, "_first"}, first, exp_first);
        chk({tag, "_spacing"}, bad_space, 0);
        chk({tag, "_done_at"}, done_at, exp_done);
        chk({tag, "_levels"}, bad_lvl, 0);
        @(negedge clk);
        chk({tag, "_done_once"}, int'(done), 0);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sound", int'(sound_on), 0);
        chk("rst_done", int'(done), 0);
        resetN = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        // Reset mid-play, asserted while a tick is high
        do_start(9, 2);
        chk("mid_busy", int'(busy), 1);
        repeat (44) @(negedge clk);
        chk("mid_tick_before", int'(tick), 1);
        resetN = 1'b0;
        #1;
        chk("mid_rst_tick", int'(tick), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_sound", int'(sound_on), 0);
        chk("mid_rst_done", int'(done), 0);
        @(negedge clk);
        resetN = 1'b1;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tick || done || busy) cnt++;
        end
        chk("mid_rst_quiet", cnt, 0);

        // A4 dur 2: 10000 PLAY cycles, ticks every 44, 227 total
        do_start(9, 2);
        observe("a4_d2", 227, 45, 44, 10001, 1);

        // REST dur 1
        do_start(12, 1);
        observe("rest_d1", 0, 0, 1, 5001, 0);

        // note 15 behaves as REST
        do_start(15, 1);
        observe("n15_d1", 0, 0, 1, 5001, 0);

        // dur 0: one busy cycle then done
        do_start(9, 0);
        observe("a4_d0", 0, 0, 44, 2, 1);

        // B4 dur 1: div 39, 128 ticks
        do_start(11, 1);
        observe("b4_d1", 128, 40, 39, 5001, 1);

        // start coinciding with final ms expiry: retrigger wins
        do_start(12, 1);
        cnt = 0;
        for (int k = 2; k <= 4999; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        do_start(12, 1);
        chk("exp_rt_no_done", int'(done) + cnt, 0);
        chk("exp_rt_busy", int'(busy), 1);
        observe("exp_rt", 0, 0, 1, 5001, 0);

        // Retrigger: A4 dur 5, then C4 dur 1 at PLAY cycle 3000
        do_start(9, 5);
        cnt = 0;
        begin
            int dn;
            dn = 0;
            for (int k = 1; k <= 2999; k++) begin
                if (k > 1) @(negedge clk);
                if (tick) cnt++;
                if (done) dn++;
            end
            chk("rt_a4_ticks", cnt, 68);
            chk("rt_a4_no_done", dn, 0);
        end
        do_start(0, 1);
        observe("rt_c4", 67, 75, 74, 5001, 1);

        // Idle with start low
        cnt = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (tick || done) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
